// File: rtl/acc_control_fsm.sv
// Multicycle control unit for the 16-bit accumulator datapath: sequences each instruction,
// drives the accumulator input-mux select and datapath strobes, and counts retired instructions.
module acc_control_fsm #(
    parameter int OPW   = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   opcode,
    input  logic             acc_zero,
    input  logic             mem_ready,
    output logic             ir_write,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             mem_read,
    output logic             mem_write,
    output logic [1:0]       alu_op,
    output logic [2:0]       acc_sel,
    output logic             acc_write,
    output logic             halted,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEM    = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
    localparam logic [OPW-1:0] OP_LUI  = OPW'(2);
    localparam logic [OPW-1:0] OP_LD   = OPW'(3);
    localparam logic [OPW-1:0] OP_ST   = OPW'(4);
    localparam logic [OPW-1:0] OP_ADD  = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(8);
    localparam logic [OPW-1:0] OP_IN   = OPW'(9);
    localparam logic [OPW-1:0] OP_BEQZ = OPW'(10);
    localparam logic [OPW-1:0] OP_JMP  = OPW'(11);
    localparam logic [OPW-1:0] OP_HALT = OPW'(15);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             retire;

    logic             ir_write_c, pc_inc_c, pc_load_c, mem_read_c, mem_write_c;
    logic             acc_write_c, halted_c;
    logic [1:0]       alu_op_c;
    logic [2:0]       acc_sel_c;

    logic             is_alu, is_wb_only, is_mem, is_branch;
    logic [OPW-1:0]   alu_diff;

    assign is_alu     = (opcode >= OP_ADD) && (opcode <= OP_OR);
    assign is_wb_only = (opcode == OP_LDI) || (opcode == OP_LUI) || (opcode == OP_IN);
    assign is_mem     = (opcode >= OP_LD) && (opcode <= OP_OR);
    assign is_branch  = (opcode == OP_BEQZ) || (opcode == OP_JMP);
    assign alu_diff   = opcode - OP_ADD;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        ir_write_c  = 1'b0;
        pc_inc_c    = 1'b0;
        pc_load_c   = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        alu_op_c    = 2'b00;
        acc_sel_c   = 3'd0;
        acc_write_c = 1'b0;
        halted_c    = 1'b0;

        case (state_q)
            FETCH: begin
                ir_write_c = 1'b1;
                mem_read_c = 1'b1;
                if (mem_ready) begin
                    pc_inc_c = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                if (is_wb_only) begin
                    state_d = WB;
                end else if (is_mem) begin
                    state_d = MEM;
                end else if (is_branch) begin
                    state_d = EXEC;
                end else if (opcode == OP_HALT) begin
                    state_d = HALT;
                    retire  = 1'b1;
                end else begin
                    // unassigned opcodes behave as a NOP and still retire
                    state_d = FETCH;
                    retire  = 1'b1;
                end
            end
            MEM: begin
                if (opcode == OP_ST) mem_write_c = 1'b1;
                else                 mem_read_c  = 1'b1;
                if (mem_ready) begin
                    if (opcode == OP_ST) begin
                        state_d = FETCH;
                        retire  = 1'b1;
                    end else if (is_alu) begin
                        state_d = EXEC;
                    end else begin
                        state_d = WB;
                    end
                end
            end
            EXEC: begin
                if (is_alu) begin
                    alu_op_c = alu_diff[1:0];
                    state_d  = WB;
                end else begin
                    pc_load_c = (opcode == OP_JMP) || ((opcode == OP_BEQZ) && acc_zero);
                    state_d   = FETCH;
                    retire    = 1'b1;
                end
            end
            WB: begin
                acc_write_c = 1'b1;
                case (opcode)
                    OP_LD:   acc_sel_c = 3'd1;
                    OP_LDI:  acc_sel_c = 3'd2;
                    OP_LUI:  acc_sel_c = 3'd3;
                    OP_IN:   acc_sel_c = 3'd4;
                    default: acc_sel_c = 3'd0;
                endcase
                state_d = FETCH;
                retire  = 1'b1;
            end
            HALT: begin
                halted_c = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    end

    // Strobes are forced low for the whole time reset is held, not just after the edge.
    assign ir_write  = ir_write_c  & ~reset;
    assign pc_inc    = pc_inc_c    & ~reset;
    assign pc_load   = pc_load_c   & ~reset;
    assign mem_read  = mem_read_c  & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign alu_op    = alu_op_c    & {2{~reset}};
    assign acc_sel   = acc_sel_c   & {3{~reset}};
    assign acc_write = acc_write_c & ~reset;
    assign halted    = halted_c    & ~reset;
    assign retired   = retired_q;

endmodule
